// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm trigger controller: FSM encodings,
// time limits and button indices.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET     = 3'd1,
        ST_ARMED   = 3'd2,
        ST_RINGING = 3'd3,
        ST_SNOOZE  = 3'd4
    } state_t;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

    // Button indices double as press priority: lower index wins.
    localparam int BTN_ARM    = 0;
    localparam int BTN_SNOOZE = 1;
    localparam int BTN_SET    = 2;
    localparam int BTN_HOUR   = 3;
    localparam int BTN_MIN    = 4;
    localparam int NUM_BTN    = 5;

    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max_value);
        return (value == max_value) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Two-flop synchronizer, counter debouncer and one-cycle rising-edge pulse
// for a single raw push-button.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            // Start as if held, so a button already down at release never fires.
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync_b;
                cnt   <= '0;
                press <= sync_b;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_trigger_ctrl.sv
// Alarm clock trigger: button handling, alarm time setting, arming, ringing
// with auto-stop and snooze, driving a registered play request.
module alarm_trigger_ctrl
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RING_SECONDS    = 60,
    parameter int SNOOZE_MIN      = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       btn_set,
    input  logic       btn_hour,
    input  logic       btn_min,
    input  logic       btn_arm,
    input  logic       btn_snooze,
    output logic       play_sound,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic [2:0] state,
    output logic       armed
);

    localparam int SNOOZE_SECONDS = SNOOZE_MIN * 60;
    localparam int CNT_TOP = (SNOOZE_SECONDS > RING_SECONDS) ? SNOOZE_SECONDS : RING_SECONDS;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECONDS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECONDS - 1);

    state_t             fsm;
    logic [CNT_W-1:0]   sec_cnt;
    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;
    logic               time_match;

    assign raw = {btn_min, btn_hour, btn_set, btn_snooze, btn_arm};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clock(clock),
            .reset(reset),
            .raw  (raw[i]),
            .press(press[i])
        );
    end

    assign time_match = tick_1hz && (cur_sec == 6'd0) &&
                        (cur_hour == alarm_hour) && (cur_min == alarm_min);
    assign state = fsm;

    // Each branch tests presses in priority order; a press that changes state
    // pre-empts any tick arriving in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm        <= ST_IDLE;
            play_sound <= 1'b0;
            armed      <= 1'b0;
            alarm_hour <= '0;
            alarm_min  <= '0;
            sec_cnt    <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (press[BTN_ARM]) begin
                        fsm   <= ST_ARMED;
                        armed <= 1'b1;
                    end else if (press[BTN_SET]) begin
                        fsm <= ST_SET;
                    end
                end
                ST_SET: begin
                    if (press[BTN_SET]) begin
                        fsm <= ST_IDLE;
                    end else if (press[BTN_HOUR]) begin
                        alarm_hour <= 5'(wrap_inc({1'b0, alarm_hour}, 6'(MAX_HOUR)));
                    end else if (press[BTN_MIN]) begin
                        alarm_min <= wrap_inc(alarm_min, 6'(MAX_MIN));
                    end
                end
                ST_ARMED: begin
                    if (press[BTN_ARM]) begin
                        fsm   <= ST_IDLE;
                        armed <= 1'b0;
                    end else if (press[BTN_SET]) begin
                        fsm   <= ST_SET;
                        armed <= 1'b0;
                    end else if (time_match) begin
                        fsm        <= ST_RINGING;
                        play_sound <= 1'b1;
                        sec_cnt    <= '0;
                    end
                end
                ST_RINGING: begin
                    if (press[BTN_ARM]) begin
                        fsm        <= ST_IDLE;
                        play_sound <= 1'b0;
                        armed      <= 1'b0;
                    end else if (press[BTN_SNOOZE]) begin
                        fsm        <= ST_SNOOZE;
                        play_sound <= 1'b0;
                        sec_cnt    <= '0;
                    end else if (tick_1hz) begin
                        if (sec_cnt == RING_LAST) begin
                            fsm        <= ST_ARMED;
                            play_sound <= 1'b0;
                        end else begin
                            sec_cnt <= sec_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (press[BTN_ARM]) begin
                        fsm   <= ST_IDLE;
                        armed <= 1'b0;
                    end else if (tick_1hz) begin
                        if (sec_cnt == SNOOZE_LAST) begin
                            fsm        <= ST_RINGING;
                            play_sound <= 1'b1;
                            sec_cnt    <= '0;
                        end else begin
                            sec_cnt <= sec_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    fsm        <= ST_IDLE;
                    play_sound <= 1'b0;
                    armed      <= 1'b0;
                end
            endcase
        end
    end

endmodule
